// File: rtl/census_pkg.sv
// Shared opcode/state encodings and code-size helpers for census_hamming_ci.
package census_pkg;

   typedef enum logic [3:0] {
      OP_CLEAR   = 4'd0,
      OP_PUSH    = 4'd1,
      OP_CENSUS  = 4'd2,
      OP_READ    = 4'd3,
      OP_LOAD    = 4'd4,
      OP_HAM     = 4'd5,
      OP_HAM_ACC = 4'd6,
      OP_ACC_SET = 4'd7
   } op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      POP  = 2'd2
   } state_e;

   function automatic int unsigned ceil_div(input int unsigned n, input int unsigned d);
      return (n + d - 1) / d;
   endfunction

   function automatic int unsigned code_w(input int unsigned win);
      return win * win - 1;
   endfunction

   function automatic int unsigned code_nw(input int unsigned win);
      return ceil_div(code_w(win), 32);
   endfunction

endpackage

// File: rtl/census_popcnt.sv
// Combinational population count of one W-bit chunk.
module census_popcnt
   import census_pkg::*;
#(
   parameter int unsigned W = 32
) (
   input  logic [W-1:0]           data_i,
   output logic [$clog2(W+1)-1:0] count_o
);

   localparam int unsigned CW = $clog2(W + 1);

   always_comb begin
      count_o = '0;
      for (int unsigned i = 0; i < W; i++) begin
         count_o = count_o + CW'(data_i[i]);
      end
   end

endmodule

// File: rtl/census_hamming_ci.sv
// Census-transform / Hamming-distance custom instruction with a WINxWIN pixel window.
// Optional accumulator (ops 6/7) is built only when CENSUS_ACC_EN is defined.
module census_hamming_ci
   import census_pkg::*;
#(
   parameter int unsigned WIN       = 11,
   parameter int unsigned PIX_W     = 8,
   parameter int unsigned POP_CHUNK = 32
) (
   input  logic        iClk,
   input  logic        iReset,
   input  logic        iClk_en,
   input  logic        iStart,
   input  logic [3:0]  iOp,
   input  logic [31:0] iA,
   input  logic [31:0] iB,
   output logic [31:0] oRes,
   output logic        oDone
);

   localparam int unsigned NPIX    = WIN * WIN;
   localparam int unsigned CODE_W  = code_w(WIN);
   localparam int unsigned NW      = code_nw(WIN);
   localparam int unsigned CODEPAD = NW * 32;
   localparam int unsigned CENTRE  = (NPIX - 1) / 2;
   localparam int unsigned P       = 32 / PIX_W;
   localparam int unsigned NCH     = ceil_div(CODE_W, POP_CHUNK);
   localparam int unsigned CHPAD   = NCH * POP_CHUNK;
   localparam int unsigned DIFFW   = (CHPAD > CODEPAD) ? CHPAD : CODEPAD;
   localparam int unsigned CNT_W   = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int unsigned POPW    = $clog2(CODE_W + 1);
   localparam int unsigned PCW     = $clog2(POP_CHUNK + 1);
   localparam logic [CODEPAD-1:0] CODE_MASK = {CODEPAD{1'b1}} >> (CODEPAD - CODE_W);

   state_e             state_q, state_d;
   logic               done_q, done_d;
   logic [31:0]        res_q, res_d;
   logic [PIX_W-1:0]   win_q [NPIX];
   logic [PIX_W-1:0]   win_d [NPIX];
   logic [CODEPAD-1:0] codea_q, codea_d;
   logic [CODEPAD-1:0] codeb_q, codeb_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [POPW-1:0]    pop_q, pop_d;
`ifdef CENSUS_ACC_EN
   logic [31:0]        acc_q, acc_d;
   logic               accm_q, accm_d;
`endif

   logic [PIX_W-1:0]     ref_pix;
   logic [CODEPAD-1:0]   census_code;
   logic [31:0]          rd_word;
   logic [DIFFW-1:0]     diff;
   logic [POP_CHUNK-1:0] chunk;
   logic [PCW-1:0]       chunk_cnt;
   logic [POPW-1:0]      pop_total;
   int unsigned          nval;

   // Code bit i skips the centre pixel, so indices at or above it shift up by one.
   always_comb begin
      ref_pix     = iB[0] ? iA[PIX_W-1:0] : win_q[CENTRE];
      census_code = '0;
      for (int unsigned i = 0; i < CODE_W; i++) begin
         census_code[i] = (win_q[(i < CENTRE) ? i : i + 1] < ref_pix);
      end
   end

   always_comb begin
      rd_word = '0;
      for (int unsigned w = 0; w < NW; w++) begin
         if (iA[3:0] == 4'(w)) rd_word = codea_q[w*32 +: 32];
      end
   end

   assign diff = DIFFW'(codea_q ^ codeb_q);

   always_comb begin
      chunk = '0;
      for (int unsigned c = 0; c < NCH; c++) begin
         if (cnt_q == CNT_W'(c)) chunk = diff[c*POP_CHUNK +: POP_CHUNK];
      end
   end

   census_popcnt #(.W(POP_CHUNK)) u_popcnt (
      .data_i  (chunk),
      .count_o (chunk_cnt)
   );

   assign pop_total = pop_q + POPW'(chunk_cnt);

   always_comb begin
      nval = int'(iB[2:0]);
      if (nval == 0 || nval > P) nval = P;
   end

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      res_d   = res_q;
      win_d   = win_q;
      codea_d = codea_q;
      codeb_d = codeb_q;
      cnt_d   = cnt_q;
      pop_d   = pop_q;
`ifdef CENSUS_ACC_EN
      acc_d   = acc_q;
      accm_d  = accm_q;
`endif
      case (state_q)
         IDLE: begin
            if (iStart) begin
               state_d = EXEC;
               done_d  = 1'b1;
               res_d   = '0;
               case (iOp)
                  OP_CLEAR: begin
                     for (int unsigned k = 0; k < NPIX; k++) win_d[k] = '1;
                     codea_d = '0;
                     codeb_d = '0;
                  end
                  OP_PUSH: begin
                     for (int unsigned k = 0; k < NPIX - P; k++) win_d[k] = win_q[k+P];
                     for (int unsigned s = 0; s < P; s++) begin
                        win_d[NPIX-P+s] = (s < nval) ? iA[s*PIX_W +: PIX_W] : '1;
                     end
                  end
                  OP_CENSUS: begin
                     codea_d = census_code;
                     res_d   = census_code[31:0];
                  end
                  OP_READ: res_d = rd_word;
                  OP_LOAD: begin
                     for (int unsigned w = 0; w < NW; w++) begin
                        if (iA[3:0] == 4'(w)) codeb_d[w*32 +: 32] = iB;
                     end
                     codeb_d = codeb_d & CODE_MASK;
                  end
                  OP_HAM: begin
                     state_d = POP;
                     done_d  = 1'b0;
                     cnt_d   = '0;
                     pop_d   = '0;
`ifdef CENSUS_ACC_EN
                     accm_d  = 1'b0;
`endif
                  end
`ifdef CENSUS_ACC_EN
                  OP_HAM_ACC: begin
                     state_d = POP;
                     done_d  = 1'b0;
                     cnt_d   = '0;
                     pop_d   = '0;
                     accm_d  = 1'b1;
                  end
                  OP_ACC_SET: begin
                     acc_d = iA;
                     res_d = iA;
                  end
`endif
                  default: ;
               endcase
            end
         end
         EXEC: state_d = IDLE;
         POP: begin
            pop_d = pop_total;
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(NCH - 1)) begin
               state_d = IDLE;
               done_d  = 1'b1;
               res_d   = 32'(pop_total);
`ifdef CENSUS_ACC_EN
               if (accm_q) begin
                  acc_d = acc_q + 32'(pop_total);
                  res_d = acc_d;
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge iClk) begin
      if (iReset) begin
         state_q <= IDLE;
         done_q  <= 1'b0;
         res_q   <= '0;
         for (int unsigned k = 0; k < NPIX; k++) win_q[k] <= '1;
         codea_q <= '0;
         codeb_q <= '0;
         cnt_q   <= '0;
         pop_q   <= '0;
`ifdef CENSUS_ACC_EN
         acc_q   <= '0;
         accm_q  <= 1'b0;
`endif
      end else if (iClk_en) begin
         state_q <= state_d;
         done_q  <= done_d;
         res_q   <= res_d;
         win_q   <= win_d;
         codea_q <= codea_d;
         codeb_q <= codeb_d;
         cnt_q   <= cnt_d;
         pop_q   <= pop_d;
`ifdef CENSUS_ACC_EN
         acc_q   <= acc_d;
         accm_q  <= accm_d;
`endif
      end
   end

   assign oDone = done_q;
   assign oRes  = res_q;

endmodule

// File: tb/tb_census_hamming_ci.sv
// Directed table-driven bench for census_hamming_ci (default parameters).
module tb_census_hamming_ci;

   logic        clk = 1'b0;
   logic        iReset, iClk_en, iStart;
   logic [3:0]  iOp;
   logic [31:0] iA, iB;
   logic [31:0] oRes;
   logic        oDone;

   int total  = 0;
   int passed = 0;

   typedef struct {
      string       name;
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      int          lat;
   } vec_t;

   vec_t tbl[$];

   census_hamming_ci #(.WIN(11), .PIX_W(8), .POP_CHUNK(32)) dut (
      .iClk    (clk),
      .iReset  (iReset),
      .iClk_en (iClk_en),
      .iStart  (iStart),
      .iOp     (iOp),
      .iA      (iA),
      .iB      (iB),
      .oRes    (oRes),
      .oDone   (oDone)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
   endtask

   // Latency counts clock edges from the edge that samples iStart to the edge that raises oDone.
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] res, output int lat);
      @(negedge clk);
      iStart = 1'b1; iOp = op; iA = a; iB = b;
      @(posedge clk); #1;
      iStart = 1'b0;
      lat = 1;
      while (!oDone && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      res = oRes;
      if (!oDone) lat = 999;
      @(posedge clk); #1;
   endtask

   task automatic add(input string n, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] r, input int l);
      vec_t v;
      v.name = n; v.op = op; v.a = a; v.b = b; v.res = r; v.lat = l;
      tbl.push_back(v);
   endtask

   task automatic run_tbl();
      logic [31:0] r;
      int          l;
      foreach (tbl[i]) begin
         run_op(tbl[i].op, tbl[i].a, tbl[i].b, r, l);
         check({tbl[i].name, "_res"}, r, tbl[i].res);
         check({tbl[i].name, "_lat"}, 32'(l), 32'(tbl[i].lat));
      end
      tbl.delete();
   endtask

   // Clear, then push pixel values 0..120 in ascending order.
   task automatic build_ramp();
      logic [31:0] r;
      int          l;
      int          bad;
      bad = 0;
      run_op(4'd0, 32'd0, 32'd0, r, l);
      if (r !== 32'd0 || l != 1) bad++;
      for (int k = 0; k < 30; k++) begin
         run_op(4'd1, {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)}, 32'd4, r, l);
         if (r !== 32'd0 || l != 1) bad++;
      end
      run_op(4'd1, 32'd120, 32'd1, r, l);
      if (r !== 32'd0 || l != 1) bad++;
      check("ramp_pushes_bad", 32'(bad), 32'd0);
   endtask

   logic [31:0] r;
   int          lat;
   int          seen;

   initial begin
      iReset = 1'b1; iClk_en = 1'b1; iStart = 1'b0; iOp = '0; iA = '0; iB = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_done", {31'd0, oDone}, 32'd0);
      check("reset_res", oRes, 32'd0);
      @(negedge clk);
      iReset = 1'b0;

      add("rst_read0", 4'd3, 32'd0, 32'd0, 32'd0, 1);
      run_tbl();

      build_ramp();
      add("census_ctr",  4'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 1);
      add("read_w0",     4'd3, 32'd0, 32'd0, 32'hFFFF_FFFF, 1);
      add("read_w1",     4'd3, 32'd1, 32'd0, 32'h0FFF_FFFF, 1);
      add("read_w2",     4'd3, 32'd2, 32'd0, 32'd0, 1);
      add("read_w3",     4'd3, 32'd3, 32'd0, 32'd0, 1);
      add("read_w4_oob", 4'd3, 32'd4, 32'd0, 32'd0, 1);
      add("ham_60",      4'd5, 32'd0, 32'd0, 32'd60, 5);
      add("unused_op9",  4'd9, 32'h1234, 32'h5678, 32'd0, 1);
      add("read_w1_kept",4'd3, 32'd1, 32'd0, 32'h0FFF_FFFF, 1);
      run_tbl();

      // Stall POP for three cycles and issue an ignored clear mid-operation.
      @(negedge clk);
      iStart = 1'b1; iOp = 4'd5; iA = '0; iB = '0;
      @(posedge clk); #1;
      iStart = 1'b0; lat = 1;
      @(posedge clk); #1; lat++;
      iStart = 1'b1; iOp = 4'd0;
      @(posedge clk); #1; lat++;
      iStart = 1'b0; iClk_en = 1'b0;
      seen = 0;
      repeat (3) begin
         @(posedge clk); #1; lat++;
         if (oDone) seen++;
      end
      iClk_en = 1'b1;
      while (!oDone && lat < 40) begin
         @(posedge clk); #1; lat++;
      end
      check("stall_early_done", 32'(seen), 32'd0);
      check("stall_lat", 32'(lat), 32'd8);
      check("stall_res", oRes, 32'd60);
      @(posedge clk); #1;
      add("ign_clear_w1", 4'd3, 32'd1, 32'd0, 32'h0FFF_FFFF, 1);
`ifdef CENSUS_ACC_EN
      add("acc_set",  4'd7, 32'd100, 32'd0, 32'd100, 1);
      add("acc_ham1", 4'd6, 32'd0, 32'd0, 32'd160, 5);
      add("acc_ham2", 4'd6, 32'd0, 32'd0, 32'd220, 5);
`else
      add("op6_unused", 4'd6, 32'd0, 32'd0, 32'd0, 1);
      add("op7_unused", 4'd7, 32'd100, 32'd0, 32'd0, 1);
`endif
      add("pre_abort_w1", 4'd3, 32'd1, 32'd0, 32'h0FFF_FFFF, 1);
      run_tbl();

      // Reset on the second POP cycle aborts without a completion pulse.
      @(negedge clk);
      iStart = 1'b1; iOp = 4'd5; iA = '0; iB = '0;
      @(posedge clk); #1;
      iStart = 1'b0;
      @(posedge clk); #1;
      iReset = 1'b1;
      @(posedge clk); #1;
      check("abort_done", {31'd0, oDone}, 32'd0);
      check("abort_res", oRes, 32'd0);
      iReset = 1'b0;
      seen = 0;
      repeat (8) begin
         @(posedge clk); #1;
         if (oDone) seen++;
      end
      check("abort_no_done", 32'(seen), 32'd0);
      add("abort_read0",   4'd3, 32'd0, 32'd0, 32'd0, 1);
      add("abort_census",  4'd2, 32'd0, 32'd0, 32'd0, 1);
      run_tbl();

      build_ramp();
      add("c2_census",    4'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 1);
      add("load_w0",      4'd4, 32'd0, 32'hFFFF_FFFF, 32'd0, 1);
      add("ham_28",       4'd5, 32'd0, 32'd0, 32'd28, 5);
      add("load_w3_mask", 4'd4, 32'd3, 32'hFFFF_FFFF, 32'd0, 1);
      add("ham_52",       4'd5, 32'd0, 32'd0, 32'd52, 5);
      add("load_w5_oob",  4'd4, 32'd5, 32'hFFFF_FFFF, 32'd0, 1);
      add("ham_52b",      4'd5, 32'd0, 32'd0, 32'd52, 5);
      add("census_ref0",  4'd2, 32'd0, 32'd1, 32'd0, 1);
      add("ham_56",       4'd5, 32'd0, 32'd0, 32'd56, 5);
      add("census_r200",  4'd2, 32'hC8, 32'd1, 32'hFFFF_FFFF, 1);
      add("r200_w3",      4'd3, 32'd3, 32'd0, 32'h001F_FFFF, 1);
      add("ham_67",       4'd5, 32'd0, 32'd0, 32'd67, 5);
      add("clr",          4'd0, 32'd0, 32'd0, 32'd0, 1);
      add("ham_clr",      4'd5, 32'd0, 32'd0, 32'd0, 5);
      add("push_v2",      4'd1, 32'h0403_0201, 32'd2, 32'd0, 1);
      add("cen_v2",       4'd2, 32'h10, 32'd1, 32'd0, 1);
      add("v2_w3",        4'd3, 32'd3, 32'd0, 32'h0030_0000, 1);
      add("clr2",         4'd0, 32'd0, 32'd0, 32'd0, 1);
      add("push_v0",      4'd1, 32'h0403_0201, 32'd0, 32'd0, 1);
      add("cen_v0",       4'd2, 32'h10, 32'd1, 32'd0, 1);
      add("v0_w3",        4'd3, 32'd3, 32'd0, 32'h00F0_0000, 1);
      add("clr3",         4'd0, 32'd0, 32'd0, 32'd0, 1);
      add("push_v7",      4'd1, 32'h0403_0201, 32'd7, 32'd0, 1);
      add("cen_v7",       4'd2, 32'h10, 32'd1, 32'd0, 1);
      add("v7_w3",        4'd3, 32'd3, 32'd0, 32'h00F0_0000, 1);
      add("clr4",         4'd0, 32'd0, 32'd0, 32'd0, 1);
      add("push_v3",      4'd1, 32'h0403_0201, 32'd3, 32'd0, 1);
      add("cen_v3",       4'd2, 32'h10, 32'd1, 32'd0, 1);
      add("v3_w3",        4'd3, 32'd3, 32'd0, 32'h0070_0000, 1);
      run_tbl();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
